// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : round-robin arbiter sharing one memory port between
//                    Fetch and LSU, one transaction outstanding, with timeout
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  instr_req_ip,
   input  logic [ADDR_WIDTH-1:0] instr_addr_ip,
   output logic                  instr_gnt_op,
   output logic [DATA_WIDTH-1:0] instr_data_op,
   output logic                  instr_data_valid_op,
   input  logic                  lsu_req_ip,
   input  logic                  lsu_we_ip,
   input  logic [ADDR_WIDTH-1:0] lsu_addr_ip,
   input  logic [DATA_WIDTH-1:0] lsu_wdata_ip,
   output logic                  lsu_gnt_op,
   output logic [DATA_WIDTH-1:0] lsu_rdata_op,
   output logic                  lsu_rdata_valid_op,
   output logic                  mem_req_op,
   output logic                  mem_we_op,
   output logic [ADDR_WIDTH-1:0] mem_addr_op,
   output logic [DATA_WIDTH-1:0] mem_wdata_op,
   input  logic                  mem_gnt_ip,
   input  logic                  mem_rvalid_ip,
   input  logic [DATA_WIDTH-1:0] mem_rdata_ip,
   output logic                  err_op
);

   localparam logic       c_OWNER_FETCH  = 1'b0;
   localparam logic       c_OWNER_LSU    = 1'b1;
   localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_owner;
   logic                  r_last_grant;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [7:0]            r_count;

   logic w_winner;
   logic w_in_req;
   logic w_in_resp;
   logic w_resp_valid;
   logic w_timeout;

   // On a tie the requester that did not win last time goes next.
   always_comb begin
      w_winner = c_OWNER_FETCH;
      if (instr_req_ip && lsu_req_ip) begin
         w_winner = ~r_last_grant;
      end else if (lsu_req_ip) begin
         w_winner = c_OWNER_LSU;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_owner      <= c_OWNER_FETCH;
         r_last_grant <= c_OWNER_LSU;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_count      <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (instr_req_ip || lsu_req_ip) begin
                  r_state      <= S_REQ;
                  r_owner      <= w_winner;
                  r_last_grant <= w_winner;
                  if (w_winner == c_OWNER_LSU) begin
                     r_we    <= lsu_we_ip;
                     r_addr  <= lsu_addr_ip;
                     r_wdata <= lsu_wdata_ip;
                  end else begin
                     r_we    <= 1'b0;
                     r_addr  <= instr_addr_ip;
                     r_wdata <= '0;
                  end
               end
            end
            S_REQ: begin
               if (mem_gnt_ip) begin
                  r_state <= S_RESP;
                  r_count <= 8'd0;
               end
            end
            S_RESP: begin
               if (mem_rvalid_ip || (r_count == c_TIMEOUT_LAST)) begin
                  r_state <= S_IDLE;
               end else begin
                  r_count <= r_count + 8'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_in_req     = (r_state == S_REQ);
   assign w_in_resp    = (r_state == S_RESP);
   assign w_resp_valid = w_in_resp && mem_rvalid_ip;
   // A response landing on the last allowed cycle still wins over the timeout.
   assign w_timeout    = w_in_resp && !mem_rvalid_ip && (r_count == c_TIMEOUT_LAST);

   assign mem_req_op   = w_in_req;
   assign mem_we_op    = w_in_req && r_we;
   assign mem_addr_op  = w_in_req ? r_addr  : '0;
   assign mem_wdata_op = w_in_req ? r_wdata : '0;

   assign instr_gnt_op = w_in_req && (r_owner == c_OWNER_FETCH) && mem_gnt_ip;
   assign lsu_gnt_op   = w_in_req && (r_owner == c_OWNER_LSU)   && mem_gnt_ip;

   assign instr_data_valid_op = w_resp_valid && (r_owner == c_OWNER_FETCH);
   assign instr_data_op       = instr_data_valid_op ? mem_rdata_ip : '0;
   assign lsu_rdata_valid_op  = w_resp_valid && (r_owner == c_OWNER_LSU);
   assign lsu_rdata_op        = (lsu_rdata_valid_op && !r_we) ? mem_rdata_ip : '0;

   assign err_op = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : directed scenarios plus random traffic against a
//                       transaction-level model of the shared memory port
// Revision: 1.0
// ============================================================================
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          instr_req_ip;
   logic [AW-1:0] instr_addr_ip;
   logic          instr_gnt_op;
   logic [DW-1:0] instr_data_op;
   logic          instr_data_valid_op;
   logic          lsu_req_ip;
   logic          lsu_we_ip;
   logic [AW-1:0] lsu_addr_ip;
   logic [DW-1:0] lsu_wdata_ip;
   logic          lsu_gnt_op;
   logic [DW-1:0] lsu_rdata_op;
   logic          lsu_rdata_valid_op;
   logic          mem_req_op;
   logic          mem_we_op;
   logic [AW-1:0] mem_addr_op;
   logic [DW-1:0] mem_wdata_op;
   logic          mem_gnt_ip;
   logic          mem_rvalid_ip;
   logic [DW-1:0] mem_rdata_ip;
   logic          err_op;

   mem_port_arbiter #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .instr_req_ip        (instr_req_ip),
      .instr_addr_ip       (instr_addr_ip),
      .instr_gnt_op        (instr_gnt_op),
      .instr_data_op       (instr_data_op),
      .instr_data_valid_op (instr_data_valid_op),
      .lsu_req_ip          (lsu_req_ip),
      .lsu_we_ip           (lsu_we_ip),
      .lsu_addr_ip         (lsu_addr_ip),
      .lsu_wdata_ip        (lsu_wdata_ip),
      .lsu_gnt_op          (lsu_gnt_op),
      .lsu_rdata_op        (lsu_rdata_op),
      .lsu_rdata_valid_op  (lsu_rdata_valid_op),
      .mem_req_op          (mem_req_op),
      .mem_we_op           (mem_we_op),
      .mem_addr_op         (mem_addr_op),
      .mem_wdata_op        (mem_wdata_op),
      .mem_gnt_ip          (mem_gnt_ip),
      .mem_rvalid_ip       (mem_rvalid_ip),
      .mem_rdata_ip        (mem_rdata_ip),
      .err_op              (err_op)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: at most one transaction, either waiting for grant or for response
   typedef enum int {T_NONE, T_WAIT_GNT, T_WAIT_RSP} txn_phase_t;
   txn_phase_t    m_phase    = T_NONE;
   logic          m_is_lsu   = 1'b0;
   logic          m_prev_lsu = 1'b1;
   logic          m_we       = 1'b0;
   logic [AW-1:0] m_addr     = '0;
   logic [DW-1:0] m_wdata    = '0;
   int            m_waited   = 0;

   logic          e_igt, e_ival, e_lgt, e_lval, e_req, e_we, e_err;
   logic [DW-1:0] e_idata, e_ldata, e_wdata;
   logic [AW-1:0] e_addr;

   task automatic model_outputs();
      e_igt = 0; e_ival = 0; e_lgt = 0; e_lval = 0; e_req = 0; e_we = 0; e_err = 0;
      e_idata = '0; e_ldata = '0; e_wdata = '0; e_addr = '0;
      if (m_phase == T_WAIT_GNT) begin
         e_req = 1; e_we = m_we; e_addr = m_addr; e_wdata = m_wdata;
         if (m_is_lsu) e_lgt = mem_gnt_ip;
         else          e_igt = mem_gnt_ip;
      end
      if (m_phase == T_WAIT_RSP) begin
         if (mem_rvalid_ip) begin
            if (m_is_lsu) begin
               e_lval  = 1;
               e_ldata = m_we ? '0 : mem_rdata_ip;
            end else begin
               e_ival  = 1;
               e_idata = mem_rdata_ip;
            end
         end else if (m_waited == TO - 1) begin
            e_err = 1;
         end
      end
   endtask

   task automatic model_update();
      logic win_lsu;
      if (reset) begin
         m_phase = T_NONE; m_prev_lsu = 1'b1; m_waited = 0;
      end else if (m_phase == T_NONE) begin
         if (instr_req_ip || lsu_req_ip) begin
            win_lsu = (instr_req_ip && lsu_req_ip) ? !m_prev_lsu : lsu_req_ip;
            m_is_lsu   = win_lsu;
            m_prev_lsu = win_lsu;
            m_we       = win_lsu ? lsu_we_ip    : 1'b0;
            m_addr     = win_lsu ? lsu_addr_ip  : instr_addr_ip;
            m_wdata    = win_lsu ? lsu_wdata_ip : '0;
            m_phase    = T_WAIT_GNT;
         end
      end else if (m_phase == T_WAIT_GNT) begin
         if (mem_gnt_ip) begin
            m_phase  = T_WAIT_RSP;
            m_waited = 0;
         end
      end else begin
         if (mem_rvalid_ip || m_waited == TO - 1) m_phase = T_NONE;
         else                                     m_waited++;
      end
   endtask

   task automatic settle();
      #1;
      model_outputs();
      check1 ("instr_gnt",   instr_gnt_op,        e_igt);
      check32("instr_data",  instr_data_op,       e_idata);
      check1 ("instr_valid", instr_data_valid_op, e_ival);
      check1 ("lsu_gnt",     lsu_gnt_op,          e_lgt);
      check32("lsu_rdata",   lsu_rdata_op,        e_ldata);
      check1 ("lsu_valid",   lsu_rdata_valid_op,  e_lval);
      check1 ("mem_req",     mem_req_op,          e_req);
      check1 ("mem_we",      mem_we_op,           e_we);
      check32("mem_addr",    mem_addr_op,         e_addr);
      check32("mem_wdata",   mem_wdata_op,        e_wdata);
      check1 ("err",         err_op,              e_err);
   endtask

   task automatic advance();
      @(posedge clock);
      model_update();
      @(negedge clock);
   endtask

   initial begin
      int  gseq[$];
      logic i_granted, l_granted;

      reset = 1; instr_req_ip = 0; instr_addr_ip = '0; lsu_req_ip = 0; lsu_we_ip = 0;
      lsu_addr_ip = '0; lsu_wdata_ip = '0; mem_gnt_ip = 0; mem_rvalid_ip = 0; mem_rdata_ip = '0;
      @(negedge clock);
      advance();
      advance();
      settle();
      check1("rst_mem_req", mem_req_op, 1'b0);
      check1("rst_err", err_op, 1'b0);

      // Fetch-only fastest transaction
      reset = 0; instr_req_ip = 1; instr_addr_ip = 32'h100;
      settle(); check1("f_c0_req", mem_req_op, 1'b0); advance();
      mem_gnt_ip = 1;
      settle();
      check1("f_c1_gnt", instr_gnt_op, 1'b1);
      check32("f_c1_addr", mem_addr_op, 32'h100);
      check1("f_c1_lgnt", lsu_gnt_op, 1'b0);
      advance();
      instr_req_ip = 0; mem_gnt_ip = 0; mem_rvalid_ip = 1; mem_rdata_ip = 32'h00A00093;
      settle();
      check1("f_c2_valid", instr_data_valid_op, 1'b1);
      check32("f_c2_data", instr_data_op, 32'h00A00093);
      check1("f_c2_lvalid", lsu_rdata_valid_op, 1'b0);
      advance();
      mem_rvalid_ip = 0;
      settle(); check1("f_c3_idle", mem_req_op, 1'b0); advance();

      // Tie from reset: grants alternate starting with Fetch
      reset = 1; advance(); reset = 0;
      instr_req_ip = 1; instr_addr_ip = 32'h104; lsu_req_ip = 1; lsu_we_ip = 0; lsu_addr_ip = 32'h200;
      mem_gnt_ip = 1; mem_rvalid_ip = 1; mem_rdata_ip = 32'h1111;
      for (int c = 0; c < 12; c++) begin
         settle();
         if (instr_gnt_op) gseq.push_back(0);
         if (lsu_gnt_op)   gseq.push_back(1);
         advance();
      end
      check32("tie_count", gseq.size(), 32'd4);
      for (int i = 0; i < 4; i++)
         check32("tie_order", (i < gseq.size()) ? gseq[i] : 2, i % 2);
      instr_req_ip = 0; lsu_req_ip = 0; mem_gnt_ip = 0; mem_rvalid_ip = 0;
      settle(); advance();

      // Store with grant delayed three cycles
      lsu_req_ip = 1; lsu_we_ip = 1; lsu_addr_ip = 32'h40; lsu_wdata_ip = 32'hDEADBEEF;
      settle(); advance();
      for (int c = 0; c < 3; c++) begin
         settle();
         check1("st_req", mem_req_op, 1'b1);
         check1("st_we", mem_we_op, 1'b1);
         check32("st_addr", mem_addr_op, 32'h40);
         check32("st_wdata", mem_wdata_op, 32'hDEADBEEF);
         advance();
      end
      mem_gnt_ip = 1;
      settle(); check1("st_gnt", lsu_gnt_op, 1'b1); advance();
      lsu_req_ip = 0; mem_gnt_ip = 0; mem_rvalid_ip = 1; mem_rdata_ip = 32'h12345678;
      settle();
      check1("st_valid", lsu_rdata_valid_op, 1'b1);
      check32("st_rdata", lsu_rdata_op, 32'h0);
      advance();
      mem_rvalid_ip = 0;

      // Load that times out, then a late response
      lsu_req_ip = 1; lsu_we_ip = 0; lsu_addr_ip = 32'h80;
      settle(); advance();
      mem_gnt_ip = 1; settle(); advance();
      lsu_req_ip = 0; mem_gnt_ip = 0;
      for (int k = 1; k <= 4; k++) begin
         settle();
         check1("to_err", err_op, k == 4);
         check1("to_valid", lsu_rdata_valid_op, 1'b0);
         advance();
      end
      mem_rvalid_ip = 1;
      settle();
      check1("to_late_valid", lsu_rdata_valid_op, 1'b0);
      check1("to_late_err", err_op, 1'b0);
      advance();
      mem_rvalid_ip = 0;

      // Reset during response wait, then the next tie goes to Fetch
      instr_req_ip = 1; instr_addr_ip = 32'h300;
      settle(); advance();
      mem_gnt_ip = 1; settle(); advance();
      instr_req_ip = 0; mem_gnt_ip = 0; reset = 1;
      settle(); advance();
      reset = 0; mem_rvalid_ip = 1; mem_rdata_ip = 32'h55;
      settle();
      check1("rr_valid", instr_data_valid_op, 1'b0);
      check32("rr_data", instr_data_op, 32'h0);
      advance();
      mem_rvalid_ip = 0; instr_req_ip = 1; lsu_req_ip = 1; lsu_we_ip = 0;
      settle(); advance();
      mem_gnt_ip = 1;
      settle();
      check1("rr_fetch_wins", instr_gnt_op, 1'b1);
      check1("rr_lsu_loses", lsu_gnt_op, 1'b0);
      advance();
      instr_req_ip = 0; lsu_req_ip = 0; mem_gnt_ip = 0; mem_rvalid_ip = 1;
      settle(); advance();

      // Stray memory strobes while idle
      mem_rvalid_ip = 1; mem_gnt_ip = 1;
      settle();
      check1("stray_req", mem_req_op, 1'b0);
      check1("stray_ivalid", instr_data_valid_op, 1'b0);
      advance();
      settle();
      check1("stray_stay_idle", mem_req_op, 1'b0);
      advance();
      mem_rvalid_ip = 0; mem_gnt_ip = 0;

      // Random traffic with protocol-abiding requesters
      i_granted = 0; l_granted = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!instr_req_ip || i_granted) begin
            instr_req_ip  = ($urandom_range(0, 2) == 0);
            instr_addr_ip = $urandom;
         end
         if (!lsu_req_ip || l_granted) begin
            lsu_req_ip   = ($urandom_range(0, 2) == 0);
            lsu_we_ip    = $urandom_range(0, 1) == 1;
            lsu_addr_ip  = $urandom;
            lsu_wdata_ip = $urandom;
         end
         mem_gnt_ip    = $urandom_range(0, 1) == 1;
         mem_rvalid_ip = ($urandom_range(0, 3) == 0);
         mem_rdata_ip  = $urandom;
         reset         = ($urandom_range(0, 99) == 0);
         settle();
         i_granted = e_igt;
         l_granted = e_lgt;
         advance();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory port between the Fetch instruction-read path and the LSU load/store path. It sits between those two requesters and the memory model, and keeps exactly one transaction outstanding. It picks the winner round-robin, latches the winning request, and drives the memory request until it is granted. It then routes the response (read data or write acknowledge) back to the owner and converts a lost response into an error pulse.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of all address ports
- DATA_WIDTH, 32, width of all data ports
- TIMEOUT_CYCLES, 255, number of cycles waited in RESP for mem_rvalid_ip before aborting (1..255; the counter is 8 bits)

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- instr_req_ip  in  1  Fetch read request; held until instr_gnt_op
- instr_addr_ip  in  ADDR_WIDTH  Fetch read address
- instr_gnt_op  out  1  Fetch request accepted by memory
- instr_data_op  out  DATA_WIDTH  instruction word; 0 when instr_data_valid_op=0
- instr_data_valid_op  out  1  one-cycle pulse, instruction valid
- lsu_req_ip  in  1  LSU request; held until lsu_gnt_op
- lsu_we_ip  in  1  1 = store, 0 = load
- lsu_addr_ip  in  ADDR_WIDTH  LSU address
- lsu_wdata_ip  in  DATA_WIDTH  store data
- lsu_gnt_op  out  1  LSU request accepted by memory
- lsu_rdata_op  out  DATA_WIDTH  load data; 0 when lsu_rdata_valid_op=0 or the transaction is a store
- lsu_rdata_valid_op  out  1  one-cycle pulse, load data valid or store complete
- mem_req_op, mem_we_op  out  1  memory request and write enable
- mem_addr_op  out  ADDR_WIDTH  memory address
- mem_wdata_op  out  DATA_WIDTH  memory write data
- mem_gnt_ip  in  1  memory accepts the current request
- mem_rvalid_ip  in  1  response valid (read data or write ack)
- mem_rdata_ip  in  DATA_WIDTH  memory read data
- err_op  out  1  one-cycle pulse on response timeout

## Operation
- States are IDLE, REQ and RESP.
- Registers:
  - state
  - owner (FETCH/LSU)
  - last_grant
  - latched we/addr/wdata
  - 8-bit timeout counter
- Arbitration happens only in IDLE:
  - if only one requester is requesting, it wins;
  - if both are requesting, the one not equal to last_grant wins.
- IDLE→REQ on the edge where any request is present:
  - latch the owner and its we/addr/wdata (Fetch: we=0, wdata=0);
  - last_grant←owner.
- In REQ:
  - mem_req_op=1, and mem_we_op/addr/wdata come from the latched values;
  - the owner's gnt_op = mem_gnt_ip (combinational), and the other gnt_op = 0;
  - on mem_gnt_ip: →RESP, counter←0.
- In RESP:
  - mem_req_op=0;
  - on mem_rvalid_ip, route a pulse to the owner: data = mem_rdata_ip for loads/fetch, data = 0 for stores; then →IDLE;
  - otherwise counter increments;
  - when counter==TIMEOUT_CYCLES-1 and there is no rvalid: err_op=1 for that cycle, no valid pulse is issued, →IDLE.
- mem_rvalid_ip in IDLE or REQ is ignored. mem_gnt_ip outside REQ is ignored.
- Once latched, a request is carried through even if the requester drops req early. Dropping req early is a protocol violation and is not flagged.
- All mem_* and requester outputs are 0 when not active.

## Timing
- Reset values:
  - state=IDLE, last_grant=LSU (so Fetch wins the first tie);
  - counter=0;
  - all outputs 0.
- Reset asserted mid-transaction aborts it the next edge. No response is delivered, and a later mem_rvalid_ip is ignored.
- Request sampled at edge T → mem_req_op high in cycle T+1.
- gnt_op is asserted in the same cycle as mem_gnt_ip.
- Fastest transaction:
  - req at cycle 0;
  - mem_req_op/gnt in cycle 1;
  - rvalid/valid pulse in cycle 2;
  - IDLE in cycle 3.
- Next mem_req_op is possible in cycle 4, so peak throughput is one transaction per 3 cycles.
- Waiting for grant in REQ has no timeout. Only RESP times out.
- rvalid arriving in the same cycle the counter reaches the limit is a valid response (no error).

## Test plan
- Fetch only, addr 0x100, mem gnt in cycle 1, rvalid+0x00A00093 in cycle 2 → instr_gnt_op in cycle 1, instr_data_valid_op/instr_data_op=0x00A00093 in cycle 2, lsu outputs 0.
- Fetch and LSU request together from reset → Fetch granted first, LSU next; with both held continuously the grants alternate F,L,F,L.
- LSU store: addr 0x40, wdata 0xDEADBEEF, mem_gnt delayed 3 cycles → mem_req_op/mem_we_op held with stable addr/wdata for 3 cycles; on rvalid, lsu_rdata_valid_op=1 with lsu_rdata_op=0.
- LSU load granted, rvalid withheld, TIMEOUT_CYCLES=4 → err_op pulse on the 4th RESP cycle, no lsu_rdata_valid_op, back in IDLE; a late rvalid is ignored.
- Reset asserted in RESP, then rvalid → no valid pulse, all outputs 0; the next tie is granted to Fetch.
- Stray mem_rvalid_ip/mem_gnt_ip pulses while in IDLE → no outputs change, state stays IDLE.
